// File: rtl/cache_lookup.sv
// cache_lookup: direct-mapped, read-only lookup cache with a pre-warmed image.
//
// A one-cycle search request latches the address. On the following edge the
// indexed line is read and its tag is compared, so results appear two edges
// after the request. search_done stays high until the next accepted search.
// search_cache is ignored while a lookup is in flight.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   search_cache  search request, sampled on a rising edge
//   address[31:0] index = address[INDEX_W-1:0], tag = address[TAG_W-1:0]
//   hit           tag matched a valid line
//   search_done   result valid; held until the next accepted search
//   data          line data on hit, 0 on miss
//   tag_out       tag of the last accepted search
//   hit_count, miss_count  (only with CACHE_STATS_EN) saturating result counters
//
// Build option: define CACHE_STATS_EN to add hit_count/miss_count.
//
// Contents are only ever the reset image: line i < WARM_LINES holds tag i and
// data i*i, every other line is invalid. There is no fill or write path, so the
// array is a fixed function of the index. It is generated as a ROM rather than
// kept in ~100k resettable flops, which would only ever reload the same values.
module cache_lookup #(
  parameter int NUM_LINES  = 1024,
  parameter int WARM_LINES = 512,
  parameter int TAG_W      = 28,
  parameter int DATA_W     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              search_cache,
  input  logic [31:0]       address,
  output logic              hit,
  output logic              search_done,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag_out
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_LINES);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  state_t             state;
  logic [TAG_W-1:0]   tag_q;    // latched lookup tag; its low bits are the index
  logic [INDEX_W-1:0] idx;
  line_t              rd_line;
  logic               lk_hit;

  assign idx = tag_q[INDEX_W-1:0];

  // Warm-image ROM read of the latched index.
  always_comb begin
    rd_line = '0;
    if (32'(idx) < WARM_LINES) begin
      rd_line.valid = 1'b1;
      rd_line.tag   = TAG_W'(idx);
      rd_line.data  = DATA_W'(idx) * DATA_W'(idx);
    end
  end

  // Aliased addresses (>= NUM_LINES) land on a line whose stored tag is the
  // line number, so the full-tag compare rejects them.
  assign lk_hit = rd_line.valid && (rd_line.tag == tag_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tag_q       <= '0;
      hit         <= 1'b0;
      search_done <= 1'b0;
      data        <= '0;
      tag_out     <= '0;
`ifdef CACHE_STATS_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (search_cache) begin
            tag_q       <= address[TAG_W-1:0];
            search_done <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit         <= lk_hit;
          data        <= lk_hit ? rd_line.data : '0;
          tag_out     <= tag_q;
          search_done <= 1'b1;
          state       <= DONE;
`ifdef CACHE_STATS_EN
          if (lk_hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup.sv
// Scoreboard bench for cache_lookup: each issued search pushes its expected
// result; a monitor pops and compares on every rising edge of search_done.
module tb_cache_lookup;

  localparam int TAG_W  = 28;
  localparam int DATA_W = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              search_cache;
  logic [31:0]       address;
  logic              hit;
  logic              search_done;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag_out;
`ifdef CACHE_STATS_EN
  logic [15:0]       hit_count, miss_count;
`endif

  cache_lookup dut (
    .clock        (clock),
    .reset        (reset),
    .search_cache (search_cache),
    .address      (address),
    .hit          (hit),
    .search_done  (search_done),
    .data         (data),
    .tag_out      (tag_out)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tg, obs, exp);
    end
  endtask

  // Reference model straight from the warm-image definition.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    int   idx;
    idx   = int'(a % 1024);
    e.tag = a[TAG_W-1:0];
    e.hit = (idx < 512) && (32'(e.tag) == 32'(idx));
    e.data = e.hit ? 64'(idx) * 64'(idx) : 64'd0;
    return e;
  endfunction

  // Monitor: compare on each new result.
  always @(negedge clock) begin
    if (reset === 1'b1 && search_done === 1'b1 && done_prev === 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit", 64'(hit), 64'(e.hit));
        chk("data", data, e.data);
        chk("tag_out", 64'(tag_out), 64'(e.tag));
        if (e.hit) exp_hits++; else exp_miss++;
      end
    end
    done_prev = search_done;
  end

  // One-cycle request, with latency and hold checks around it.
  task automatic search(input logic [31:0] a);
    exp_t e;
    e = model(a);
    @(negedge clock);
    search_cache = 1'b1;
    address      = a;
    sb.push_back(e);
    @(negedge clock);
    search_cache = 1'b0;
    address      = $urandom;
    chk("done_cleared", 64'(search_done), 64'd0);
    @(negedge clock);
    chk("done_latency", 64'(search_done), 64'd1);
    @(negedge clock);
    chk("hold_hit", 64'(hit), 64'(e.hit));
    chk("hold_done", 64'(search_done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[6];
    logic [5:0]  done_seq;
    addrs = '{32'd0, 32'd255, 32'd511, 32'd1023, 32'd1536, 32'h1000_0007};

    reset        = 1'b0;
    search_cache = 1'b0;
    address      = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (13) @(negedge clock);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_done", 64'(search_done), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);

    foreach (addrs[i]) search(addrs[i]);
    for (int i = 0; i < 4; i++) search($urandom_range(0, 2047));

    // Held request: accepted on edges 1, 3, 5.
    for (int i = 0; i < 3; i++) sb.push_back(model(32'd3));
    @(negedge clock);
    search_cache = 1'b1;
    address      = 32'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      done_seq[i] = search_done;
    end
    search_cache = 1'b0;
    chk("held_done_toggle", 64'(done_seq), 64'(6'b101010));

    // Reset during LOOKUP aborts the search.
    @(negedge clock);
    search_cache = 1'b1;
    address      = 32'd7;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_hit", 64'(hit), 64'd0);
    chk("abort_done", 64'(search_done), 64'd0);
    chk("abort_data", data, 64'd0);
    chk("abort_tag", 64'(tag_out), 64'd0);
    sb.delete();
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clock);
    search_cache = 1'b0;
    reset        = 1'b1;
    search(32'd5);
    search(32'd600);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
`ifdef CACHE_STATS_EN
    chk("hit_count", 64'(hit_count), 64'(exp_hits));
    chk("miss_count", 64'(miss_count), 64'(exp_miss));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
